// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
// The generator drives the bit-stream sequence detectors in this codebase.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int MAXLEN_DEFAULT = 8;
  localparam int CNTW_DEFAULT   = 4;

  // Wide enough to hold every length from 0 up to MAXLEN inclusive.
  function automatic int lenw_for(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits a captured pattern MSB-first, reps times,
// with optional zero gaps between repetitions and a mark on each last bit.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEFAULT,
  parameter int LENW   = lenw_for(MAXLEN),
  parameter int CNTW   = CNTW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   len,
  input  logic [CNTW-1:0]   reps,
  input  logic [CNTW-1:0]   gap,
  input  logic              hold,
  output logic              dout,
  output logic              dout_valid,
  output logic              mark,
  output logic              busy,
  output logic              done
);

  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);
  localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_t            state, state_n;
  logic [MAXLEN-1:0] sh_pattern, sh_pattern_n;
  logic [LENW-1:0]   sh_len, sh_len_n;
  logic [CNTW-1:0]   sh_gap, sh_gap_n;
  logic [LENW-1:0]   idx, idx_n;
  logic [CNTW-1:0]   reps_left, reps_left_n;
  logic [CNTW-1:0]   gap_left, gap_left_n;
  logic              dout_n, dout_valid_n, mark_n, busy_n, done_n;

  logic              fire;
  logic [LENW-1:0]   fire_idx;
  logic [CNTW-1:0]   fire_reps;
  logic [CNTW-1:0]   reps_dec;
  logic [MAXLEN-1:0] pat_sel;
  logic [MAXLEN-1:0] pat_shift;
  logic [LENW-1:0]   len_sel;
  logic [CNTW-1:0]   gap_sel;
  logic [LENW-1:0]   len_clamped;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh_pattern <= '0;
      sh_len     <= '0;
      sh_gap     <= '0;
      idx        <= '0;
      reps_left  <= '0;
      gap_left   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      mark       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sh_pattern <= sh_pattern_n;
      sh_len     <= sh_len_n;
      sh_gap     <= sh_gap_n;
      idx        <= idx_n;
      reps_left  <= reps_left_n;
      gap_left   <= gap_left_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      mark       <= mark_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // "fire" means this edge emits one data bit; the start edge fires too, so
  // the first bit leaves one cycle after start using the live inputs.
  always_comb begin
    state_n      = state;
    sh_pattern_n = sh_pattern;
    sh_len_n     = sh_len;
    sh_gap_n     = sh_gap;
    idx_n        = idx;
    reps_left_n  = reps_left;
    gap_left_n   = gap_left;
    dout_n       = 1'b0;
    dout_valid_n = 1'b0;
    mark_n       = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    fire         = 1'b0;
    fire_idx     = idx;
    fire_reps    = reps_left;
    pat_sel      = sh_pattern;
    len_sel      = sh_len;
    gap_sel      = sh_gap;
    reps_dec     = '0;
    pat_shift    = '0;
    len_clamped  = (len > MAXLEN_L) ? MAXLEN_L : len;

    case (state)
      IDLE: begin
        if (start) begin
          sh_pattern_n = pattern;
          sh_len_n     = len_clamped;
          sh_gap_n     = gap;
          reps_left_n  = reps;
          gap_left_n   = '0;
          if (len_clamped == '0 || reps == '0) begin
            // Nothing to send: raise done now so it lands where a normal
            // first bit would; FIN then sees done already high.
            idx_n   = '0;
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            fire      = 1'b1;
            fire_idx  = len_clamped - LEN_ONE;
            fire_reps = reps;
            pat_sel   = pattern;
            len_sel   = len_clamped;
            gap_sel   = gap;
          end
        end
      end
      SHIFT: begin
        busy_n = 1'b1;
        if (hold) begin
          dout_n = dout;
        end else begin
          fire = 1'b1;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (hold) begin
          dout_n = dout;
        end else begin
          dout_valid_n = 1'b1;
          if (gap_left > CNT_ONE) begin
            gap_left_n = gap_left - CNT_ONE;
          end else begin
            gap_left_n = '0;
            state_n    = SHIFT;
          end
        end
      end
      FIN: begin
        done_n  = ~done;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (fire) begin
      pat_shift    = pat_sel >> fire_idx;
      dout_n       = pat_shift[0];
      dout_valid_n = 1'b1;
      busy_n       = 1'b1;
      if (fire_idx == '0) begin
        mark_n      = 1'b1;
        reps_dec    = (fire_reps != '0) ? fire_reps - CNT_ONE : '0;
        reps_left_n = reps_dec;
        idx_n       = len_sel - LEN_ONE;
        if (reps_dec == '0) begin
          state_n = FIN;
        end else if (gap_sel != '0) begin
          gap_left_n = gap_sel;
          state_n    = GAP;
        end else begin
          state_n = SHIFT;
        end
      end else begin
        idx_n       = fire_idx - LEN_ONE;
        reps_left_n = fire_reps;
        state_n     = SHIFT;
      end
    end
  end

endmodule
